// File: rtl/note_mode_ctrl.sv
// Note-driven mode controller: filters note events, commits mode at frame boundaries,
// and generates the animation step and sweep counters. NOTE_MODE_CTRL_TIMEOUT_EN adds silence timeout.
module note_mode_ctrl #(
  parameter int unsigned screen_width  = 640,
  parameter int unsigned screen_height = 480,
  parameter int unsigned w_x           = $clog2(screen_width),
  parameter int unsigned w_y           = $clog2(screen_height),
  parameter int unsigned step_period   = 1048576,
  parameter int unsigned n_confirm     = 3,
  parameter int unsigned timeout_steps = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           note_vld,
  input  logic [3:0]     note_idx,
  input  logic           frame_start,
  input  logic           key_up,
  input  logic           key_down,
  output logic [1:0]     mode,
  output logic [3:0]     cur_note,
  output logic           step,
  output logic [w_x-1:0] cnt1,
  output logic [w_y-1:0] cnt2,
  output logic           busy
);

  localparam int unsigned    WDiv     = $clog2(step_period);
  localparam logic [WDiv-1:0] DivMax  = WDiv'(step_period - 1);
  localparam logic [WDiv-1:0] DivOne  = WDiv'(1);
  localparam logic [w_x-1:0] XMax     = w_x'(screen_width - 1);
  localparam logic [w_x-1:0] XOne     = w_x'(1);
  localparam logic [w_y-1:0] YMax     = w_y'(screen_height - 1);
  localparam logic [w_y-1:0] YMid     = w_y'(screen_height / 2);
  localparam logic [w_y-1:0] YOne     = w_y'(1);
  localparam logic [3:0]     NConf    = 4'(n_confirm);
  localparam logic [3:0]     NoteNone = 4'hF;

  typedef enum logic [1:0] {StIdle, StTrack, StPending} state_e;

  state_e          state_q, state_d;
  logic [WDiv-1:0] div_q, div_d;
  logic            step_q, step_d;
  logic [w_x-1:0]  cnt1_q, cnt1_d;
  logic [w_y-1:0]  cnt2_q, cnt2_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      match_q, match_d;
  logic [3:0]      pend_q, pend_d;
  logic [3:0]      cur_q, cur_d;
  logic [1:0]      mode_q, mode_d;
  logic            note_ok, confirm, commit, timeout;
  logic [1:0]      pend_mod3;

`ifdef NOTE_MODE_CTRL_TIMEOUT_EN
  localparam int unsigned     WSil   = $clog2(timeout_steps + 1);
  localparam logic [WSil-1:0] SilMax = WSil'(timeout_steps);
  localparam logic [WSil-1:0] SilOne = WSil'(1);
  logic [WSil-1:0] sil_q, sil_d;
`endif

  always_comb begin
    note_ok   = note_vld && (note_idx < 4'd12);
    // Confirm fires only on the note that brings the run to exactly n_confirm.
    confirm   = note_ok && ((note_idx == cand_q) ? (match_q == NConf - 4'd1) : (NConf == 4'd1));
    commit    = (state_q == StPending) && frame_start;
    pend_mod3 = 2'(pend_q % 4'd3);

    div_d  = (div_q == DivMax) ? '0 : div_q + DivOne;
    step_d = (div_q == DivMax);

    cnt1_d = cnt1_q;
    if (step_q) cnt1_d = (cnt1_q == XMax) ? '0 : cnt1_q + XOne;
    if (commit) cnt1_d = '0;

    cnt2_d = cnt2_q;
    if (step_q) begin
      if (cnt2_q == '0 || cnt2_q == YMax)   cnt2_d = YMid;
      else if (key_up && !key_down)         cnt2_d = cnt2_q + YOne;
      else if (key_down && !key_up)         cnt2_d = cnt2_q - YOne;
    end

    cand_d  = cand_q;
    match_d = match_q;
    if (note_ok) begin
      if (note_idx == cand_q) begin
        match_d = (match_q == NConf) ? match_q : match_q + 4'd1;
      end else begin
        cand_d  = note_idx;
        match_d = 4'd1;
      end
    end

`ifdef NOTE_MODE_CTRL_TIMEOUT_EN
    sil_d = sil_q;
    if (step_q && sil_q != SilMax) sil_d = sil_q + SilOne;
    if (note_ok || commit)         sil_d = '0;
    timeout = (state_q == StTrack) && (sil_q == SilMax) && (cur_q != NoteNone) && !note_ok;
`else
    timeout = 1'b0;
`endif

    state_d = state_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle, StTrack: begin
        if (note_ok) state_d = StTrack;
        if (confirm && note_idx != cur_q) begin
          state_d = StPending;
          pend_d  = note_idx;
        end else if (timeout) begin
          state_d = StPending;
          pend_d  = NoteNone;
        end
      end
      StPending: begin
        // A frame boundary commits the old pending note even if a confirm lands with it.
        if (frame_start) begin
          cur_d   = pend_q;
          mode_d  = (pend_q == NoteNone) ? 2'd3 : pend_mod3;
          state_d = StTrack;
        end else if (confirm && note_idx != pend_q) begin
          pend_d = note_idx;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      step_q  <= 1'b0;
      cnt1_q  <= '0;
      cnt2_q  <= YMid;
      cand_q  <= NoteNone;
      match_q <= 4'd0;
      pend_q  <= NoteNone;
      cur_q   <= NoteNone;
      mode_q  <= 2'd3;
`ifdef NOTE_MODE_CTRL_TIMEOUT_EN
      sil_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      step_q  <= step_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      mode_q  <= mode_d;
`ifdef NOTE_MODE_CTRL_TIMEOUT_EN
      sil_q   <= sil_d;
`endif
    end
  end

  assign mode     = mode_q;
  assign cur_note = cur_q;
  assign step     = step_q;
  assign cnt1     = cnt1_q;
  assign cnt2     = cnt2_q;
  assign busy     = (state_q == StPending);

endmodule

// File: tb/tb_note_mode_ctrl.sv
// Bench for note_mode_ctrl: cycle-level behavioural model compared every cycle,
// plus directed literal checks on the key scenarios.
module tb_note_mode_ctrl;
  localparam int SW = 16;
  localparam int SH = 8;
  localparam int P  = 4;
  localparam int N  = 3;
  localparam int T  = 8;

  logic       clk, rst, note_vld, frame_start, key_up, key_down;
  logic [3:0] note_idx;
  logic [1:0] mode;
  logic [3:0] cur_note;
  logic       step, busy;
  logic [3:0] cnt1;
  logic [2:0] cnt2;

  note_mode_ctrl #(
    .screen_width (SW),
    .screen_height(SH),
    .step_period  (P),
    .n_confirm    (N),
    .timeout_steps(T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .note_vld   (note_vld),
    .note_idx   (note_idx),
    .frame_start(frame_start),
    .key_up     (key_up),
    .key_down   (key_down),
    .mode       (mode),
    .cur_note   (cur_note),
    .step       (step),
    .cnt1       (cnt1),
    .cnt2       (cnt2),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model state: edges since reset, unsaturated run length, pending flag.
  int m_n, m_cnt1, m_cnt2, m_cur, m_pend, m_last, m_run, m_sil;
  bit m_step, m_pending, m_init;
  bit prev_step, vnote, conf, commit_now, tmo;

  always @(posedge clk) begin
    m_init <= 1'b1;
    if (!rst) begin
      m_n = 0; m_cnt1 = 0; m_cnt2 = SH / 2; m_cur = 15; m_pend = 15;
      m_last = -1; m_run = 0; m_sil = 0; m_step = 0; m_pending = 0;
    end else begin
      prev_step = m_step;
      m_n++;
      m_step = (m_n % P == 0);
      vnote = note_vld && (note_idx < 12);
      commit_now = m_pending && frame_start;
      conf = 0;
      tmo = 0;
`ifdef NOTE_MODE_CTRL_TIMEOUT_EN
      tmo = !m_pending && (m_sil >= T) && (m_cur != 15) && !vnote;
      if (vnote || commit_now) m_sil = 0;
      else if (prev_step && m_sil < T) m_sil++;
`endif
      if (vnote) begin
        if (int'(note_idx) == m_last) m_run++;
        else begin m_last = int'(note_idx); m_run = 1; end
        conf = (m_run == N);
      end
      if (prev_step) m_cnt1 = (m_cnt1 + 1) % SW;
      if (commit_now) m_cnt1 = 0;
      if (prev_step) begin
        if (m_cnt2 == 0 || m_cnt2 == SH - 1) m_cnt2 = SH / 2;
        else m_cnt2 = m_cnt2 + int'(key_up) - int'(key_down);
      end
      if (commit_now) begin
        m_cur = m_pend; m_pending = 0;
      end else if (m_pending) begin
        if (conf && int'(note_idx) != m_pend) m_pend = int'(note_idx);
      end else if (conf && int'(note_idx) != m_cur) begin
        m_pending = 1; m_pend = int'(note_idx);
      end else if (tmo) begin
        m_pending = 1; m_pend = 15;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("mode", int'(mode), (m_cur == 15) ? 3 : m_cur % 3);
      chk("cur_note", int'(cur_note), m_cur);
      chk("step", int'(step), int'(m_step));
      chk("cnt1", int'(cnt1), m_cnt1);
      chk("cnt2", int'(cnt2), m_cnt2);
      chk("busy", int'(busy), int'(m_pending));
    end
  end

  task automatic send_note(input int n);
    note_vld = 1'b1; note_idx = 4'(n);
    @(negedge clk);
    note_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_step_then_edge();
    int k;
    k = 0;
    while (!step && k < 2 * P) begin @(negedge clk); k++; end
    if (!step) chk("step_timeout", 0, 1);
    @(negedge clk);
  endtask

  int exp_seq[4] = '{5, 6, 7, 4};
  int held;

  initial begin
    rst = 1'b0; note_vld = 1'b0; note_idx = '0; frame_start = 1'b0;
    key_up = 1'b0; key_down = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mode", int'(mode), 3);
    chk("rst_cur", int'(cur_note), 15);
    chk("rst_cnt1", int'(cnt1), 0);
    chk("rst_cnt2", int'(cnt2), 4);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    repeat (70) @(negedge clk);

    send_note(5); send_note(5); send_note(5);
    chk("confirm5_busy", int'(busy), 1);
    pulse_frame();
    chk("commit5_mode", int'(mode), 2);
    chk("commit5_cur", int'(cur_note), 5);
    chk("commit5_cnt1", int'(cnt1), 0);
    chk("commit5_busy", int'(busy), 0);

    send_note(5); send_note(7); send_note(5); send_note(5);
    chk("broken_run_busy", int'(busy), 0);
    send_note(4); send_note(14); send_note(4); send_note(4);
    chk("confirm4_busy", int'(busy), 1);
    pulse_frame();
    chk("commit4_cur", int'(cur_note), 4);
    chk("commit4_mode", int'(mode), 1);

    key_up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_step_then_edge();
      chk("cnt2_up_seq", int'(cnt2), exp_seq[i]);
    end
    key_down = 1'b1;
    held = int'(cnt2);
    repeat (12) @(negedge clk);
    chk("cnt2_both_hold", int'(cnt2), held);
    key_up = 1'b0; key_down = 1'b0;

    send_note(5); send_note(5); send_note(5);
    send_note(1); send_note(1); send_note(1);
    chk("overwrite_busy", int'(busy), 1);
    pulse_frame();
    chk("overwrite_mode", int'(mode), 1);
    chk("overwrite_cur", int'(cur_note), 1);

    send_note(2); send_note(2); send_note(2);
    note_vld = 1'b1; note_idx = 4'd3;
    pulse_frame();
    note_vld = 1'b0;
    chk("simul_cur", int'(cur_note), 2);
    chk("simul_mode", int'(mode), 2);
    @(negedge clk);
    send_note(3); send_note(3);
    chk("simul_match_busy", int'(busy), 1);
    pulse_frame();
    chk("commit3_mode", int'(mode), 0);

    send_note(5); send_note(5); send_note(5);
    pulse_frame();
    chk("pre_timeout_cur", int'(cur_note), 5);
    repeat (40) @(negedge clk);
    pulse_frame();
`ifdef NOTE_MODE_CTRL_TIMEOUT_EN
    chk("timeout_mode", int'(mode), 3);
    chk("timeout_cur", int'(cur_note), 15);
`else
    chk("no_timeout_mode", int'(mode), 2);
    chk("no_timeout_cur", int'(cur_note), 5);
`endif
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
